// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - digit-serial adder, DIGIT_W bits per clock via a registered carry chain
// Optional accumulate mode (operand A taken from Sum) under `define SERIAL_ADDER_ACCUM_EN.
module serial_digit_adder #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_ACCUM_EN
  input  logic             accumulate,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_cfg
      $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT_W");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_sha;
  logic [WIDTH-1:0]   r_shb;
  logic [WIDTH-1:0]   r_psum;
  logic [WIDTH-1:0]   r_sum;
  logic               r_c;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;

  logic [DIGIT_W:0]         w_digit;
  logic [WIDTH+DIGIT_W-1:0] w_cat;
  logic [WIDTH-1:0]         w_psum_next;
  logic [WIDTH-1:0]         w_opa;
  logic                     w_accept;
  logic                     w_last;

  assign w_digit = {1'b0, r_sha[DIGIT_W-1:0]} + {1'b0, r_shb[DIGIT_W-1:0]}
                 + {{DIGIT_W{1'b0}}, r_c};
  // New digit enters at the MSB end; the concatenation also covers N=1 cleanly.
  assign w_cat       = {w_digit[DIGIT_W-1:0], r_psum};
  assign w_psum_next = w_cat[WIDTH+DIGIT_W-1:DIGIT_W];
  assign w_last      = (r_cnt == CW'(N - 1));
  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SERIAL_ADDER_ACCUM_EN
  assign w_opa = accumulate ? r_sum : A;
`else
  assign w_opa = A;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_BUSY: begin
          r_sha  <= r_sha >> DIGIT_W;
          r_shb  <= r_shb >> DIGIT_W;
          r_psum <= w_psum_next;
          r_c    <= w_digit[DIGIT_W];
          r_cnt  <= r_cnt + 1'b1;
          // Sum/Carry only change here, so partial results never leak out.
          if (w_last) begin
            r_sum   <= w_psum_next;
            r_carry <= w_digit[DIGIT_W];
            r_state <= S_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            r_sha   <= w_opa;
            r_shb   <= B;
            r_c     <= Cin;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (r_state == S_BUSY);
  assign done  = (r_state == S_DONE);
  assign Sum   = r_sum;
  assign Carry = r_carry;

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Parametrised, multi-cycle successor to the combinational half adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT_W bits per clock, through a registered carry chain.
- Uses a start/busy/done handshake.
- Used wherever area matters more than latency: shared arithmetic datapaths and slow control counters.

Parameters:
- WIDTH, 8, operand and Sum width in bits. Must be ≥1.
- DIGIT_W, 1, bits added per clock. WIDTH must be an integer multiple of DIGIT_W; elaboration error otherwise.
- N (localparam), WIDTH/DIGIT_W, digit cycles per addition.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled on clk rising edge
- A  input  WIDTH  operand A; captured when start is accepted
- B  input  WIDTH  operand B; captured when start is accepted
- Cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse: Sum and Carry have just been updated
- Sum  output  WIDTH  registered result; held between operations
- Carry  output  1  registered carry-out of the MSB digit; held with Sum

Behaviour:
- Interface (already decided): one clock domain, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE; busy=0, done=0, Sum=0, Carry=0. Internal operand shift registers, partial-sum register, digit counter and carry register all cleared. Reset takes effect immediately, independent of clk.
- States: IDLE, BUSY, DONE (2-bit encoded register).
- Start acceptance: start is accepted in IDLE or DONE on edge E.
  - Latch A, B, Cin into internal registers.
  - Counter=0; state becomes BUSY at E.
- BUSY, each edge:
  - digit = shA[DIGIT_W-1:0] + shB[DIGIT_W-1:0] + c, computed DIGIT_W+1 bits wide.
  - Low DIGIT_W bits enter the partial-sum register from the MSB end (shift right by DIGIT_W).
  - The top bit becomes the new c.
  - shA and shB shift right by DIGIT_W; counter increments.
- Completion, on the edge processing digit N-1 (edge E+N):
  - Sum <= completed partial sum; Carry <= final c.
  - done <= 1; state becomes DONE.
- DONE lasts exactly one cycle. Next edge: done <= 0 and state returns to IDLE, or to BUSY if start is high (back-to-back operation).
- busy = 1 exactly in BUSY, i.e. N consecutive cycles after acceptance. busy and done are never high together.
- Latency: start sampled at E gives done high during the cycle following edge E+N. Throughput is one result per N+1 cycles.
- Sum/Carry stability: they keep the previous result throughout BUSY. Partial results are never visible.
- Ignored inputs:
  - start while BUSY.
  - A, B, Cin changes after acceptance.
- Wrap-around: the sum is modulo 2^WIDTH. The overflow bit appears only on Carry.
- Degenerate case: WIDTH=DIGIT_W gives N=1, a registered full adder with 1-cycle busy.
- Reset mid-operation: the operation aborts, no done pulse, all outputs return to 0.

Optional Feature:
- Macro: SERIAL_ADDER_ACCUM_EN.
- When defined:
  - Adds input port accumulate (1 bit), sampled with start.
  - If accumulate=1 at acceptance, operand A is replaced by the current Sum register value and the A port is ignored.
  - Cin still applies. Carry reports the carry-out of that accumulation step.
  - Accumulate immediately after reset accumulates onto 0.
- When not defined: the accumulate port is absent and A is always used. Behaviour is otherwise identical.

Test Plan:
- Reset: drive rst_n=0 mid-clock with no edge. Sum=0, Carry=0, busy=0, done=0 immediately. Release; state stays IDLE with start=0.
- WIDTH=8, DIGIT_W=1 carry cases:
  - A=8'h0F, B=8'h01, Cin=0, start for 1 cycle: busy high exactly 8 cycles, then done pulses 1 cycle, Sum=8'h10, Carry=0.
  - A=8'hFF, B=8'h01, Cin=0: Sum=8'h00, Carry=1.
  - A=8'hFF, B=8'hFF, Cin=1: Sum=8'hFF, Carry=1.
  - Sum holds its old value during busy in all three cases.
- WIDTH=8, DIGIT_W=4: A=8'h9A, B=8'h77, Cin=0. busy high 2 cycles, Sum=8'h11, Carry=1. Back-to-back: start held high in the DONE cycle with A=8'h01, B=8'h01 → Sum=8'h02 two cycles later.
- Protocol robustness:
  - Start A=8'h10, B=8'h20.
  - Pulse start with A=8'hAA, B=8'h55 during busy: ignored, result 8'h30.
  - Next operation: assert rst_n=0 after the 3rd busy cycle. No done pulse; outputs return to 0.
- WIDTH=1, DIGIT_W=1: exhaustive A, B, Cin (8 combos). {Carry, Sum} equals A+B+Cin; each done arrives 1 cycle after busy.
- SERIAL_ADDER_ACCUM_EN defined:
  - A=8'h05, B=8'h03 → Sum=8'h08.
  - Then accumulate=1, B=8'h10 → Sum=8'h18, Carry=0.
  - Then accumulate=1, B=8'hF0 → Sum=8'h08, Carry=1.
